usb_sample_framer: RTL and testbench
====================================

Name: usb_sample_framer

Overview:
- Sits between the FX2 EP2 receive path (byte strobe plus data from the slave-FIFO read state machine) and the FFT core input.
- Assembles host bytes into 16-bit signed samples and stores one full frame of 2**ADDR_W samples.
- Streams the frame out with a valid/ready handshake, marking the first and last samples.
- Fill and drain are mutually exclusive (single buffer), so the FFT always sees a complete, contiguous frame.

Parameters:
- ADDR_W, 8, log2 of frame length in samples (frame = 256 samples = 512 bytes).
- BIG_ENDIAN, 0, byte order within a sample: 0 = low byte first, 1 = high byte first.

Ports:
- clk  input  1  single clock (FX2 interface clock)
- reset  input  1  synchronous, active-high reset
- in_valid  input  1  byte available from FX2 read path
- in_data  input  8  byte from host
- in_ready  output  1  framer accepts byte this cycle
- frame_sync  input  1  realign strobe: restart current frame fill
- out_valid  output  1  sample valid toward FFT
- out_ready  input  1  FFT accepts sample
- out_data  output  16  assembled sample
- out_first  output  1  marks sample index 0 of frame
- out_last  output  1  marks sample index 2**ADDR_W-1
- busy  output  1  high while in DRAIN
- frame_count  output  8  completed frames drained, wraps 255->0

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high.
- Reset values:
  - state=FILL, byte phase=0, write index=0, read index=0.
  - out_valid=0, out_first=0, out_last=0, out_data=0.
  - busy=0, frame_count=0, in_ready=1 from the first cycle after reset deassertion.
  - Buffer contents are not reset.
- Byte transfer: a byte is accepted when in_valid & in_ready at a posedge.
- Sample assembly:
  - Phase 0 captures the first byte into a holding register.
  - Phase 1 forms the 16-bit sample and writes it to RAM[write index] in the same cycle.
  - BIG_ENDIAN=0: sample = {byte1, byte0}. BIG_ENDIAN=1: sample = {byte0, byte1}.
- FILL state:
  - in_ready=1, busy=0.
  - Write index increments after each sample write.
  - The write of sample 2**ADDR_W-1 moves the state to DRAIN on the next cycle. Write index wraps to 0 and byte phase is 0.
- frame_sync in FILL:
  - Clears byte phase and write index on the next edge.
  - A byte accepted in the same cycle as frame_sync is treated as phase-0 byte 0 of the new frame; the old partial frame is discarded.
- frame_sync in DRAIN: ignored.
- DRAIN state:
  - in_ready=0, busy=1.
  - RAM read is registered (1-cycle latency). A prefetch/skid register provides zero-bubble streaming.
  - First out_valid=1 no later than 2 cycles after entering DRAIN.
  - With out_ready held high, one sample is transferred per cycle, so 256 samples take 256 consecutive cycles after the first valid.
  - While out_valid & ~out_ready: out_data, out_first and out_last stay stable, and out_valid stays high.
  - out_first=1 only with sample 0. out_last=1 only with sample 2**ADDR_W-1.
- End of frame:
  - The transfer of the last sample (out_valid & out_ready & out_last) returns the state to FILL on the next cycle.
  - The same edge increments frame_count modulo 256.
  - out_valid=0 and in_ready=1 in the following cycle.
- Arithmetic: indices are ADDR_W bits and wrap naturally. No saturation. Samples are passed through unmodified (two's complement preserved).
- Reset mid-operation (either state): the next edge returns to reset values. Any partial frame or in-flight output is dropped, and out_valid drops immediately after that edge.
- Simultaneous events: out_ready is ignored when out_valid=0. in_valid is ignored when in_ready=0, and the byte is not consumed.

Test Plan:
- Fill-and-drain:
  - Stimulus: after reset, send 512 bytes, byte k = k mod 256, in_valid continuous, out_ready=1.
  - Required: 256 samples out, sample n = {(2n+1) mod 256, (2n) mod 256} (e.g. sample 0 = 0x0100, sample 1 = 0x0302); out_first with n=0 only, out_last with n=255 only; frame_count=1; in_ready=0 throughout DRAIN.
- Backpressure:
  - Stimulus: toggle out_ready 1,0,0,1 repeating during DRAIN.
  - Required: no sample lost or duplicated; out_data stable while stalled; still exactly 256 transfers.
- Realign:
  - Stimulus: send 301 bytes, pulse frame_sync, then send 512 bytes 0xA5,0x5A repeating.
  - Required: exactly one frame out, all samples = 0x5AA5 (BIG_ENDIAN=0) or 0xA55A (BIG_ENDIAN=1).
- Input gated in DRAIN:
  - Stimulus: hold in_valid=1 during DRAIN with in_data=0xFF.
  - Required: in_ready=0; the next frame's first sample comes from bytes offered after return to FILL.
- Reset mid-drain:
  - Stimulus: assert reset after 100 output transfers.
  - Required: out_valid=0 the cycle after the reset edge, frame_count=0, in_ready=1; a fresh 512-byte frame drains correctly.
- Wrap counters:
  - Stimulus: run 257 frames.
  - Required: frame_count reads 1; write and read indices wrap with no off-by-one (the first sample of each frame matches byte pair 0).

Source files
------------

// File: rtl/usb_sample_framer.sv
// usb_sample_framer: packs FX2 EP2 bytes into 16-bit samples and buffers
// one frame, then streams it to the FFT with first/last markers.
module usb_sample_framer #(
  parameter int ADDR_W     = 8,
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  input  logic        frame_sync,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        out_first,
  output logic        out_last,
  output logic        busy,
  output logic [7:0]  frame_count
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  typedef enum logic {
    FILL,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  logic              phase_q;
  logic [7:0]        hold_q;
  logic [ADDR_W-1:0] widx_q;
  logic [ADDR_W-1:0] ridx_q;
  logic [ADDR_W-1:0] ridx_nxt;
  logic [15:0]       mem [DEPTH];

  logic        accept;
  logic        wr_en;
  logic        fill_done;
  logic        fire;
  logic        prime;
  logic        advance;
  logic [15:0] sample;

  assign accept    = in_valid & in_ready;
  assign wr_en     = accept & phase_q & ~frame_sync;
  assign fill_done = wr_en & (widx_q == LAST_IDX);
  assign sample    = BIG_ENDIAN ? {hold_q, in_data}
                                : {in_data, hold_q};

  assign fire     = out_valid & out_ready;
  assign prime    = (state_q == DRAIN) & ~out_valid;
  assign advance  = prime | (fire & ~out_last);
  assign ridx_nxt = prime ? '0 : ridx_q + ADDR_W'(1);

  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    unique case (state_q)
      FILL: begin
        in_ready = 1'b1;
        if (fill_done) state_d = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (fire & out_last) state_d = FILL;
      end
    endcase
  end

  // A byte arriving with frame_sync becomes byte 0 of the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= 1'b0;
      widx_q  <= '0;
    end else if (state_q == FILL) begin
      if (frame_sync) begin
        phase_q <= accept;
        widx_q  <= '0;
      end else if (accept) begin
        phase_q <= ~phase_q;
        if (phase_q) widx_q <= widx_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept & (~phase_q | frame_sync)) hold_q <= in_data;
    if (wr_en) mem[widx_q] <= sample;
  end

  // out_data is the RAM read register; the read address is picked from
  // this cycle's handshake, so the next word lands with no bubble and
  // a stall simply re-holds the register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_first   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      ridx_q      <= '0;
      frame_count <= '0;
    end else if (state_q == DRAIN) begin
      if (advance) begin
        out_valid <= 1'b1;
        out_data  <= mem[ridx_nxt];
        out_first <= prime;
        out_last  <= (ridx_nxt == LAST_IDX);
        ridx_q    <= ridx_nxt;
      end else if (fire) begin
        out_valid   <= 1'b0;
        out_first   <= 1'b0;
        out_last    <= 1'b0;
        ridx_q      <= '0;
        frame_count <= frame_count + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_usb_sample_framer.sv
// tb_usb_sample_framer: directed vectors for the sample framer, plus a
// small-frame big-endian instance for the 257-frame counter wrap.
module tb_usb_sample_framer;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        frame_sync;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_first;
  logic        out_last;
  logic        busy;
  logic [7:0]  frame_count;

  logic        s_in_valid;
  logic [7:0]  s_in_data;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [15:0] s_out_data;
  logic        s_out_first;
  logic        s_out_last;
  logic        s_busy;
  logic [7:0]  s_frame_count;

  always #5 clk = ~clk;

  usb_sample_framer #(.ADDR_W(8), .BIG_ENDIAN(1'b0)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .frame_sync(frame_sync),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_first(out_first), .out_last(out_last),
    .busy(busy), .frame_count(frame_count)
  );

  usb_sample_framer #(.ADDR_W(2), .BIG_ENDIAN(1'b1)) sdut (
    .clk(clk), .reset(reset),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .frame_sync(1'b0),
    .out_valid(s_out_valid), .out_ready(1'b1),
    .out_data(s_out_data), .out_first(s_out_first),
    .out_last(s_out_last),
    .busy(s_busy), .frame_count(s_frame_count)
  );

  typedef struct {
    logic [7:0]  b0;
    logic [7:0]  b1;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[8];

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  bq[$];
  logic [17:0] rx[$];
  int          rxc[$];
  int          cyc = 0;
  int          dcyc = 0;
  int          busy_cyc = 0;
  bit          prev_busy = 0;
  bit          rdy_bp = 0;
  bit          gate_ff = 0;
  bit          sync_pend = 0;
  bit          prev_stall = 0;
  bit          end_chk = 0;
  logic [17:0] prev_out;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (end_chk) begin
      check("end_out_valid", 32'(out_valid), 0);
      check("end_in_ready", 32'(in_ready), 1);
      end_chk = 0;
    end
    if (prev_stall) begin
      check("stall_valid", 32'(out_valid), 1);
      check("stall_hold", 32'({out_first, out_last, out_data}),
            32'(prev_out));
    end
    if (busy) check("drain_in_ready", 32'(in_ready), 0);
    if (busy && !prev_busy) busy_cyc = cyc;
    prev_busy = busy;
    frame_sync = sync_pend;
    sync_pend = 0;
    if (!in_ready && gate_ff) begin
      in_valid = 1'b1;
      in_data  = 8'hFF;
    end else if (bq.size() > 0) begin
      in_valid = 1'b1;
      in_data  = bq[0];
      if (in_ready) bq.delete(0);
    end else begin
      in_valid = 1'b0;
      in_data  = 8'h00;
    end
    out_ready = rdy_bp ? ((dcyc % 4 == 0) || (dcyc % 4 == 3)) : 1'b1;
    if (busy) dcyc++;
    if (out_valid && out_ready) begin
      rx.push_back({out_first, out_last, out_data});
      rxc.push_back(cyc);
      if (out_last) end_chk = 1;
    end
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_first, out_last, out_data};
    cyc++;
  endtask

  task automatic run_until(input int n_rx, input int budget);
    int c = 0;
    while (rx.size() < n_rx && c < budget) begin
      cycle();
      c++;
    end
    check("rx_count", 32'(rx.size()), 32'(n_rx));
    cycle();
  endtask

  task automatic flush_bytes(input int budget);
    int c = 0;
    while (bq.size() > 0 && c < budget) begin
      cycle();
      c++;
    end
    check("bytes_flushed", 32'(bq.size()), 0);
  endtask

  task automatic push_ramp(input int off);
    for (int k = 0; k < 512; k++) bq.push_back(8'((k + off) % 256));
  endtask

  task automatic check_ramp(input int base, input int off);
    logic [15:0] e;
    for (int n = 0; n < 256; n++) begin
      e = {8'((2*n + 1 + off) % 256), 8'((2*n + off) % 256)};
      check($sformatf("ramp_s%0d", n), 32'(rx[base+n]),
            32'({n == 0, n == 255, e}));
    end
  endtask

  task automatic check_const(input string name, input logic [15:0] e);
    for (int n = 0; n < 256; n++)
      check($sformatf("%s_s%0d", name, n), 32'(rx[n]),
            32'({n == 0, n == 255, e}));
  endtask

  task automatic clear_rx();
    rx.delete();
    rxc.delete();
    dcyc = 0;
  endtask

  initial begin
    int c;
    int k;
    int n;
    logic [15:0] e;

    tbl[0] = '{8'h00, 8'h01, 16'h0100};
    tbl[1] = '{8'hA5, 8'h5A, 16'h5AA5};
    tbl[2] = '{8'hFF, 8'h7F, 16'h7FFF};
    tbl[3] = '{8'h00, 8'h80, 16'h8000};
    tbl[4] = '{8'hFF, 8'hFF, 16'hFFFF};
    tbl[5] = '{8'h34, 8'h12, 16'h1234};
    tbl[6] = '{8'h01, 8'h00, 16'h0001};
    tbl[7] = '{8'hCD, 8'hAB, 16'hABCD};

    reset = 1'b1;
    in_valid = 0; in_data = 0; frame_sync = 0; out_ready = 0;
    s_in_valid = 0; s_in_data = 0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_first", 32'(out_first), 0);
    check("rst_out_last", 32'(out_last), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_frame_count", 32'(frame_count), 0);
    check("rst_in_ready", 32'(in_ready), 1);

    // fill and drain with a byte ramp
    push_ramp(0);
    run_until(256, 2000);
    check_ramp(0, 0);
    check("fd_frame_count", 32'(frame_count), 1);
    check("fd_first_latency", 32'((rxc[0] - busy_cyc) <= 2), 1);
    check("fd_stream_cycles", 32'(rxc[255] - rxc[0]), 255);

    // table-driven sample assembly
    clear_rx();
    for (int i = 0; i < 256; i++) begin
      bq.push_back(tbl[i % 8].b0);
      bq.push_back(tbl[i % 8].b1);
    end
    run_until(256, 2000);
    for (int i = 0; i < 256; i++)
      check($sformatf("tbl_s%0d", i), 32'(rx[i]),
            32'({i == 0, i == 255, tbl[i % 8].exp}));
    check("tbl_frame_count", 32'(frame_count), 2);

    // backpressure 1,0,0,1
    clear_rx();
    rdy_bp = 1;
    push_ramp(3);
    run_until(256, 3000);
    repeat (20) cycle();
    rdy_bp = 0;
    check("bp_total", 32'(rx.size()), 256);
    check_ramp(0, 3);
    check("bp_frame_count", 32'(frame_count), 3);

    // realign after an odd 301-byte partial frame
    clear_rx();
    for (int i = 0; i < 301; i++) bq.push_back(8'(i));
    flush_bytes(1000);
    sync_pend = 1;
    cycle();
    for (int i = 0; i < 256; i++) begin
      bq.push_back(8'hA5);
      bq.push_back(8'h5A);
    end
    run_until(256, 2000);
    repeat (40) cycle();
    check("ra_total", 32'(rx.size()), 256);
    check_const("ra", 16'h5AA5);
    check("ra_frame_count", 32'(frame_count), 4);

    // frame_sync arriving together with the new frame's first byte
    clear_rx();
    for (int i = 0; i < 101; i++) bq.push_back(8'h11);
    flush_bytes(1000);
    for (int i = 0; i < 256; i++) begin
      bq.push_back(8'hA5);
      bq.push_back(8'h5A);
    end
    sync_pend = 1;
    run_until(256, 2000);
    repeat (40) cycle();
    check("rs_total", 32'(rx.size()), 256);
    check_const("rs", 16'h5AA5);
    check("rs_frame_count", 32'(frame_count), 5);

    // input offered with 0xFF throughout DRAIN
    clear_rx();
    gate_ff = 1;
    push_ramp(0);
    push_ramp(7);
    run_until(512, 4000);
    gate_ff = 0;
    check_ramp(0, 0);
    check("gate_first", 32'(rx[256]), 32'({2'b10, 16'h0807}));
    check_ramp(256, 7);
    check("gate_frame_count", 32'(frame_count), 7);

    // reset in the middle of a drain
    clear_rx();
    push_ramp(0);
    run_until(100, 2000);
    @(negedge clk);
    reset = 1'b1;
    in_valid = 0; frame_sync = 0; out_ready = 1;
    bq.delete();
    @(negedge clk);
    reset = 1'b0;
    check("mr_out_valid", 32'(out_valid), 0);
    check("mr_frame_count", 32'(frame_count), 0);
    check("mr_in_ready", 32'(in_ready), 1);
    check("mr_busy", 32'(busy), 0);
    prev_stall = 0; end_chk = 0; prev_busy = 0;
    clear_rx();
    push_ramp(0);
    run_until(256, 2000);
    check_ramp(0, 0);
    check("mr_frame_count2", 32'(frame_count), 1);

    // 257 four-sample big-endian frames on the small instance
    for (int f = 0; f < 257; f++) begin
      k = 0;
      c = 0;
      while (k < 8 && c < 100) begin
        @(negedge clk);
        s_in_valid = 1'b1;
        s_in_data  = 8'((f + k) % 256);
        if (s_in_ready) k++;
        c++;
      end
      check("wr_send", 32'(k), 8);
      @(negedge clk);
      s_in_valid = 1'b0;
      n = 0;
      c = 0;
      while (n < 4 && c < 50) begin
        if (s_out_valid) begin
          e = {8'((f + 2*n) % 256), 8'((f + 2*n + 1) % 256)};
          check($sformatf("wr_f%0d_s%0d", f, n),
                32'({s_out_first, s_out_last, s_out_data}),
                32'({n == 0, n == 3, e}));
          n++;
        end
        if (n < 4) @(negedge clk);
        c++;
      end
      check("wr_recv", 32'(n), 4);
    end
    repeat (3) @(negedge clk);
    check("wr_frame_count", 32'(s_frame_count), 1);
    check("wr_in_ready", 32'(s_in_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
